coin_feeder: RTL and testbench
==============================

// Module: coin_feeder
// PURPOSE
//  Customer-side initiator for the vending coin bus: drives coin[1:0] into the vending FSM and consumes its
//  dispense/chg5 pulses. Holds a loadable wallet of 5- and 10-unit coins; on start it feeds coins until a vend
//  completes. Tracks expected credit and flags any dispense/chg5 response that disagrees with the protocol.
//  Used as bench stimulus and as a self-checking peer of the vending FSM.
// PARAMETERS
//  PRICE       20  item price in units; must equal the vending FSM price (20)
//  PREFER_TEN  1   1: spend tens before fives; 0: spend fives before tens
//  WALLET_W    4   width of each wallet counter (max 15 coins per denomination)
// PORTS
//  clk         in   1         rising-edge clock
//  rst         in   1         asynchronous, active-high reset
//  load        in   1         load wallet from load_fives/load_tens (honoured in IDLE only)
//  load_fives  in   WALLET_W  5-unit coin count to load
//  load_tens   in   WALLET_W  10-unit coin count to load
//  start       in   1         begin a purchase (honoured in IDLE only)
//  dispense    in   1         1-cycle pulse from vending FSM
//  chg5        in   1         1-cycle change pulse from vending FSM
//  coin        out  2         01=5, 10=10, 00=idle; one coin per SEND cycle
//  busy        out  1         high in SEND/WAIT
//  done        out  1         1-cycle pulse on purchase end (success or error)
//  vend_ok     out  1         sticky: last purchase dispensed; cleared on start
//  change_got  out  1         sticky: last purchase returned 5; cleared on start
//  err_funds   out  1         sticky: wallet empty before price reached; cleared on start
//  err_proto   out  1         sticky: response mismatch; cleared on start
//  fives_left  out  WALLET_W  current 5-coin count
//  tens_left   out  WALLET_W  current 10-coin count
// BEHAVIOUR
//  Reset (async): state=IDLE, coin=00, credit=0, wallets=0, all flags/done/busy=0; coin=00 immediately.
//  credit: 5-bit, range 0..25, mirrors vending FSM credit.
//  IDLE: coin=00. load -> wallets <= load values next edge. start -> clear sticky flags, go SEND.
//   load and start same cycle: load wins, start ignored. start/load outside IDLE ignored.
//  SEND (1 cycle): pick denomination (PREFER_TEN order, fall back to other if preferred empty).
//   Both empty -> coin=00, go FAIL with err_funds; credit retained (machine still holds it).
//   Else drive coin code, decrement that wallet, credit += value, go WAIT.
//  WAIT (1 cycle): coin=00; sample dispense/chg5 (FSM outputs are registered, arrive here).
//   exp_disp = credit>=PRICE; exp_chg = credit==PRICE+5.
//   dispense!=exp_disp or chg5!=exp_chg -> FAIL with err_proto, credit<=0.
//   match & exp_disp -> DONE; vend_ok=1; if chg5: change_got=1, fives += 1 (saturate at max).
//   match & !exp_disp -> SEND. Any dispense/chg5 outside WAIT -> err_proto (latched, takes FAIL at next WAIT/IDLE).
//  DONE (1 cycle): done=1, credit<=0, -> IDLE.  FAIL (1 cycle): done=1, -> IDLE.
//  Latency: coins spaced every 2 cycles; 10+10 purchase = start + 4 cycles to done.
//  Reset mid-operation: abandon purchase, credit=0; vending FSM must share rst.
// STRUCTURE
//  Package vend_pkg: COIN_IDLE=2'b00, COIN_FIVE=2'b01, COIN_TEN=2'b10, PRICE=20, feeder state
//   encodings IDLE/SEND/WAIT/DONE/FAIL.
//  Sub-module coin_wallet (x2): WALLET_W counter with load, decrement, saturating increment,
//   empty flag; async reset to 0.
//  Top: one state register + combinational next-state/coin decode + credit register + sticky flags.
// TESTING (paired with the vending FSM unless noted)
//  1 load 0 fives/2 tens, start, PREFER_TEN=1 -> coin 10,00,10,00; dispense in 2nd WAIT; done, vend_ok=1, change_got=0.
//  2 load 1 five/2 tens, PREFER_TEN=0 -> coins 5,10,10; credit 25; dispense+chg5; change_got=1, fives_left=1.
//  3 load 3 fives/0 tens, start -> 3 fives sent, credit 15, done with err_funds=1; reload 1 five, start -> dispense, vend_ok=1.
//  4 peer model forces dispense in WAIT at credit 10 -> err_proto=1, done pulse, credit cleared.
//  5 load+start asserted same cycle in IDLE -> wallet loaded, busy stays 0; start during WAIT ignored.
//  6 assert rst mid-SEND (async, between edges) -> coin=00 and busy=0 before next edge; wallets=0.

Source files
------------

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vend_pkg
//  Description : Shared coin codes, vend price and coin-feeder state encoding
//                for the vending coin bus.
//  Revision    : 1.0  initial release
// ============================================================================
package vend_pkg;

   // Coin bus codes driven toward the vending FSM
   localparam logic [1:0] COIN_IDLE = 2'b00;
   localparam logic [1:0] COIN_FIVE = 2'b01;
   localparam logic [1:0] COIN_TEN  = 2'b10;

   // Item price shared with the vending FSM
   localparam int VEND_PRICE = 20;

   // Coin feeder states (explicit 3-bit encoding)
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SEND = 3'd1,
      WAIT = 3'd2,
      DONE = 3'd3,
      FAIL = 3'd4
   } feeder_state_t;

   // Credit value of a coin code; idle or illegal codes carry no value
   function automatic logic [4:0] coin_value(input logic [1:0] code);
      case (code)
         COIN_FIVE: return 5'd5;
         COIN_TEN:  return 5'd10;
         default:   return 5'd0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/coin_wallet.sv
`default_nettype none
// ============================================================================
//  Module      : coin_wallet
//  Description : Per-denomination coin counter with load, decrement,
//                saturating increment and empty flag.
//  Revision    : 1.0  initial release
// ============================================================================
module coin_wallet #(
   parameter int WALLET_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_load,
   input  logic [WALLET_W-1:0] i_load_val,
   input  logic                i_dec,
   input  logic                i_inc,
   output logic [WALLET_W-1:0] o_count,
   output logic                o_empty
);

   localparam logic [WALLET_W-1:0] C_MAX  = '1;
   localparam logic [WALLET_W-1:0] C_ZERO = '0;
   localparam logic [WALLET_W-1:0] C_ONE  = WALLET_W'(1);

   logic [WALLET_W-1:0] r_count;

   // Load has priority; decrement never underflows, increment saturates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= C_ZERO;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != C_ZERO)) begin
         r_count <= r_count - C_ONE;
      end else if (i_inc && (r_count != C_MAX)) begin
         r_count <= r_count + C_ONE;
      end
   end

   assign o_count = r_count;
   assign o_empty = (r_count == C_ZERO);

endmodule
`default_nettype wire

// File: rtl/coin_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : coin_feeder
//  Description : Customer-side coin bus initiator. Feeds coins from a loadable
//                wallet until a vend completes, tracks the expected credit and
//                flags dispense/chg5 responses that disagree with it.
//  Revision    : 1.0  initial release
// ============================================================================
module coin_feeder
   import vend_pkg::*;
#(
   parameter int PRICE      = VEND_PRICE,
   parameter int PREFER_TEN = 1,
   parameter int WALLET_W   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [WALLET_W-1:0] load_fives,
   input  logic [WALLET_W-1:0] load_tens,
   input  logic                start,
   input  logic                dispense,
   input  logic                chg5,
   output logic [1:0]          coin,
   output logic                busy,
   output logic                done,
   output logic                vend_ok,
   output logic                change_got,
   output logic                err_funds,
   output logic                err_proto,
   output logic [WALLET_W-1:0] fives_left,
   output logic [WALLET_W-1:0] tens_left
);

   localparam logic [4:0] C_PRICE     = 5'(PRICE);
   localparam logic [4:0] C_PRICE_CHG = 5'(PRICE + 5);
   localparam bit         C_TEN_FIRST = (PREFER_TEN != 0);

   feeder_state_t r_state, w_state_nxt;
   logic [4:0]    r_credit;
   logic          r_stray;
   logic          r_vend_ok, r_change_got, r_err_funds, r_err_proto;

   logic w_fives_empty, w_tens_empty;
   logic w_pick_ten, w_pick_five;
   logic w_exp_disp, w_exp_chg, w_match;
   logic w_stray_now, w_load, w_start;
   logic w_dec_five, w_dec_ten, w_inc_five;
   logic w_set_vend, w_set_chg, w_set_funds, w_set_proto, w_take_stray;

   // A pending stray response blocks IDLE commands until it has been reported
   assign w_load  = (r_state == IDLE) && !r_stray && load;
   assign w_start = (r_state == IDLE) && !r_stray && start && !load;

   // Preferred denomination first, the other one only when it runs out
   assign w_pick_ten  = !w_tens_empty  && (C_TEN_FIRST  || w_fives_empty);
   assign w_pick_five = !w_fives_empty && (!C_TEN_FIRST || w_tens_empty);

   // Credit already includes the coin sent in the preceding SEND cycle
   assign w_exp_disp  = (r_credit >= C_PRICE);
   assign w_exp_chg   = (r_credit == C_PRICE_CHG);
   assign w_match     = (dispense == w_exp_disp) && (chg5 == w_exp_chg);
   assign w_stray_now = (dispense || chg5) && (r_state != WAIT);

   coin_wallet #(.WALLET_W(WALLET_W)) u_fives (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (load_fives),
      .i_dec      (w_dec_five),
      .i_inc      (w_inc_five),
      .o_count    (fives_left),
      .o_empty    (w_fives_empty)
   );

   coin_wallet #(.WALLET_W(WALLET_W)) u_tens (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (load_tens),
      .i_dec      (w_dec_ten),
      .i_inc      (1'b0),
      .o_count    (tens_left),
      .o_empty    (w_tens_empty)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, coin decode and wallet/flag strobes
   always_comb begin
      w_state_nxt  = r_state;
      coin         = COIN_IDLE;
      w_dec_five   = 1'b0;
      w_dec_ten    = 1'b0;
      w_inc_five   = 1'b0;
      w_set_vend   = 1'b0;
      w_set_chg    = 1'b0;
      w_set_funds  = 1'b0;
      w_set_proto  = 1'b0;
      w_take_stray = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_stray) begin
               w_state_nxt  = FAIL;
               w_set_proto  = 1'b1;
               w_take_stray = 1'b1;
            end else if (w_start) begin
               w_state_nxt = SEND;
            end
         end
         SEND: begin
            if (w_pick_ten) begin
               coin        = COIN_TEN;
               w_dec_ten   = 1'b1;
               w_state_nxt = WAIT;
            end else if (w_pick_five) begin
               coin        = COIN_FIVE;
               w_dec_five  = 1'b1;
               w_state_nxt = WAIT;
            end else begin
               w_set_funds = 1'b1;
               w_state_nxt = FAIL;
            end
         end
         WAIT: begin
            if (r_stray || !w_match) begin
               w_set_proto  = 1'b1;
               w_take_stray = r_stray;
               w_state_nxt  = FAIL;
            end else if (w_exp_disp) begin
               w_set_vend  = 1'b1;
               w_set_chg   = chg5;
               w_inc_five  = chg5;
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = SEND;
            end
         end
         DONE:    w_state_nxt = IDLE;
         FAIL:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Credit mirror: grows per coin, cleared on vend or protocol error,
   // kept on a funds failure because the machine still holds it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_credit <= 5'd0;
      end else if (r_state == SEND) begin
         r_credit <= r_credit + coin_value(coin);
      end else if ((r_state == DONE) || w_set_proto) begin
         r_credit <= 5'd0;
      end
   end

   // Sticky result flags and pending-stray latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vend_ok    <= 1'b0;
         r_change_got <= 1'b0;
         r_err_funds  <= 1'b0;
         r_err_proto  <= 1'b0;
         r_stray      <= 1'b0;
      end else begin
         if (w_start) begin
            r_vend_ok    <= 1'b0;
            r_change_got <= 1'b0;
            r_err_funds  <= 1'b0;
            r_err_proto  <= w_stray_now;
         end else begin
            if (w_set_vend)                 r_vend_ok    <= 1'b1;
            if (w_set_chg)                  r_change_got <= 1'b1;
            if (w_set_funds)                r_err_funds  <= 1'b1;
            if (w_set_proto || w_stray_now) r_err_proto  <= 1'b1;
         end
         if (w_stray_now) begin
            r_stray <= 1'b1;
         end else if (w_take_stray) begin
            r_stray <= 1'b0;
         end
      end
   end

   assign busy       = (r_state == SEND) || (r_state == WAIT);
   assign done       = (r_state == DONE) || (r_state == FAIL);
   assign vend_ok    = r_vend_ok;
   assign change_got = r_change_got;
   assign err_funds  = r_err_funds;
   assign err_proto  = r_err_proto;

endmodule
`default_nettype wire

// File: tb/tb_coin_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_feeder
//  Description : Self-checking bench for coin_feeder with a behavioural
//                vending-FSM peer and queue-based scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_coin_feeder;

   logic       clk = 1'b0;
   logic       rst;
   logic       load, start;
   logic [3:0] load_fives, load_tens;
   logic       dispense, chg5;
   logic [1:0] coin;
   logic       busy, done, vend_ok, change_got, err_funds, err_proto;
   logic [3:0] fives_left, tens_left;

   int n_pass  = 0;
   int n_total = 0;

   int          exp_coin[$];
   logic [11:0] exp_rec[$];

   // Peer model state
   logic [1:0] coin_s = 2'b00;
   logic [5:0] m_cred;
   logic [5:0] peer_sum;
   logic       force_disp = 1'b0;

   coin_feeder #(.PRICE(20), .PREFER_TEN(1), .WALLET_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_fives (load_fives),
      .load_tens  (load_tens),
      .start      (start),
      .dispense   (dispense),
      .chg5       (chg5),
      .coin       (coin),
      .busy       (busy),
      .done       (done),
      .vend_ok    (vend_ok),
      .change_got (change_got),
      .err_funds  (err_funds),
      .err_proto  (err_proto),
      .fives_left (fives_left),
      .tens_left  (tens_left)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [11:0] mk_rec(input bit v, input bit c, input bit fu, input bit p,
                                         input int f, input int t);
      logic [3:0] f4, t4;
      f4 = 4'(f);
      t4 = 4'(t);
      return {v, c, fu, p, f4, t4};
   endfunction

   // Behavioural vending FSM: registered dispense/chg5 one cycle after a coin
   always @(negedge clk) coin_s = coin;
   always_comb peer_sum = m_cred + ((coin_s == 2'b01) ? 6'd5 : 6'd10);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cred   <= 6'd0;
         dispense <= 1'b0;
         chg5     <= 1'b0;
      end else begin
         dispense <= 1'b0;
         chg5     <= 1'b0;
         if (coin_s == 2'b01 || coin_s == 2'b10) begin
            if (force_disp) begin
               dispense <= 1'b1;
               m_cred   <= 6'd0;
            end else if (peer_sum >= 6'd20) begin
               dispense <= 1'b1;
               chg5     <= (peer_sum == 6'd25);
               m_cred   <= 6'd0;
            end else begin
               m_cred <= peer_sum;
            end
         end
      end
   end

   // Scoreboard monitor: coins and end-of-purchase records
   always @(negedge clk) begin
      if (!rst && coin != 2'b00) begin
         if (exp_coin.size() == 0) chk("coin_unexpected", int'(coin), 0);
         else chk("coin", int'(coin), exp_coin.pop_front());
      end
      if (!rst && done) begin
         if (exp_rec.size() == 0) chk("done_unexpected", 1, 0);
         else chk("record{vok,chg,funds,proto,f,t}",
                  int'({vend_ok, change_got, err_funds, err_proto, fives_left, tens_left}),
                  int'(exp_rec.pop_front()));
      end
   end

   task automatic do_load(input int f, input int t);
      @(posedge clk); #1;
      load = 1'b1; load_fives = 4'(f); load_tens = 4'(t);
      @(posedge clk); #1;
      load = 1'b0;
   endtask

   task automatic do_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("done_seen", int'(seen), 1);
   endtask

   task automatic purchase(input int f, input int t, input logic [11:0] rec);
      exp_rec.push_back(rec);
      do_load(f, t);
      do_start();
      wait_done();
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; start = 1'b0; load_fives = 4'd0; load_tens = 4'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_coin", int'(coin), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_flags", int'({vend_ok, change_got, err_funds, err_proto}), 0);
      chk("rst_wallets", int'({fives_left, tens_left}), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_coin", int'(coin), 0);
      chk("idle_busy", int'(busy), 0);

      // Two tens, tens preferred
      exp_coin.push_back(2); exp_coin.push_back(2);
      purchase(0, 2, mk_rec(1, 0, 0, 0, 0, 0));

      // One five only: wallet runs dry at credit 5
      exp_coin.push_back(1);
      purchase(1, 0, mk_rec(0, 0, 1, 0, 0, 0));
      // Retained 5 + 10 + 10 = 25: dispense with change, five returned to wallet
      exp_coin.push_back(2); exp_coin.push_back(2);
      purchase(0, 2, mk_rec(1, 1, 0, 0, 1, 0));

      // Three fives: funds error at 15, then one more five completes at 20
      exp_coin.push_back(1); exp_coin.push_back(1); exp_coin.push_back(1);
      purchase(3, 0, mk_rec(0, 0, 1, 0, 0, 0));
      exp_coin.push_back(1);
      purchase(1, 0, mk_rec(1, 0, 0, 0, 0, 0));

      // Peer dispenses early at credit 10: protocol error
      force_disp = 1'b1;
      exp_coin.push_back(2);
      purchase(0, 2, mk_rec(0, 0, 0, 1, 0, 1));
      force_disp = 1'b0;
      // Credit must have been cleared: a fresh 10+10 vends normally
      exp_coin.push_back(2); exp_coin.push_back(2);
      purchase(0, 2, mk_rec(1, 0, 0, 0, 0, 0));

      // load and start together: load wins, no purchase begins
      @(posedge clk); #1;
      load = 1'b1; start = 1'b1; load_fives = 4'd2; load_tens = 4'd1;
      @(posedge clk); #1;
      load = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("ls_busy", int'(busy), 0);
      chk("ls_wallets", int'({fives_left, tens_left}), 8'h21);
      @(negedge clk);
      chk("ls_busy_later", int'(busy), 0);
      // Purchase 10,5,5; load/start during WAIT must be ignored
      exp_coin.push_back(2); exp_coin.push_back(1); exp_coin.push_back(1);
      exp_rec.push_back(mk_rec(1, 0, 0, 0, 0, 0));
      do_start();
      @(posedge clk); #1;
      load = 1'b1; start = 1'b1; load_fives = 4'd15; load_tens = 4'd15;
      @(posedge clk); #1;
      load = 1'b0; start = 1'b0;
      wait_done();

      // Asynchronous reset in the middle of a SEND cycle
      do_load(2, 2);
      do_start();
      chk("pre_reset_busy", int'(busy), 1);
      chk("pre_reset_coin", int'(coin), 2);
      #1 rst = 1'b1;
      #1;
      chk("async_coin", int'(coin), 0);
      chk("async_busy", int'(busy), 0);
      chk("async_wallets", int'({fives_left, tens_left}), 0);
      chk("async_flags", int'({vend_ok, err_proto}), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("post_reset_busy", int'(busy), 0);

      chk("coin_queue_empty", exp_coin.size(), 0);
      chk("rec_queue_empty", exp_rec.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
